stopwatch_cu: RTL and testbench

Control unit for the stopwatch mode of the watch/stopwatch design. Converts debounced button levels into a STOP/RUN/CLEAR sequence for the stopwatch counter datapath: it drives the datapath's run-enable and clear, and optionally a lap-hold that freezes the display. It sits beside the watch-mode control unit and is active only while its mode is selected (`cs`). The counters keep running in the background when it is not selected.

---
 rtl/stopwatch_cu.sv | 118 +++++++++++
 tb/tb_stopwatch_cu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_cu.sv
// Stopwatch-mode control unit: turns debounced button levels into STOP/RUN/CLEAR
// control for the counter datapath. Optional lap-hold support under STOPWATCH_LAP_EN.
module stopwatch_cu #(
    parameter int CLEAR_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    input  logic       i_btn_lap,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_lap_hold,
    output logic [1:0] o_state
);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        STOP    = 2'b00,
        RUN     = 2'b01,
        CLEAR   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          run_d, clear_d;
    logic          run_ev, clear_ev;

    // Previous levels track every cycle so a button held while cs rises gives no event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_d   <= 1'b0;
            clear_d <= 1'b0;
        end else begin
            run_d   <= i_btn_run;
            clear_d <= i_btn_clear;
        end
    end

    assign run_ev   = cs & i_btn_run & ~run_d;
    assign clear_ev = cs & i_btn_clear & ~clear_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= STOP;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            STOP: begin
                if (clear_ev)
                    state_next = CLEAR;
                else if (run_ev)
                    state_next = RUN;
            end
            RUN: begin
                if (run_ev)
                    state_next = STOP;
            end
            CLEAR: begin
                // The pulse runs to completion even if cs drops meanwhile.
                if (cnt_reg == CNT_LAST)
                    state_next = STOP;
                else
                    cnt_next = cnt_reg + CW'(1);
            end
            default: state_next = STOP;
        endcase
    end

    assign o_run   = (state_reg == RUN);
    assign o_clear = (state_reg == CLEAR);
    assign o_state = state_reg;

`ifdef STOPWATCH_LAP_EN
    logic lap_d, lap_ev;
    logic hold_reg, hold_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_d    <= 1'b0;
            hold_reg <= 1'b0;
        end else begin
            lap_d    <= i_btn_lap;
            hold_reg <= hold_next;
        end
    end

    assign lap_ev = cs & i_btn_lap & ~lap_d;

    always_comb begin
        hold_next = hold_reg;
        if (state_reg == CLEAR || state_next == CLEAR)
            hold_next = 1'b0;
        else if (lap_ev && state_reg == RUN)
            hold_next = ~hold_reg;
        else if (lap_ev && state_reg == STOP)
            hold_next = 1'b0;
    end

    assign o_lap_hold = hold_reg;
`else
    logic unused_lap;
    assign unused_lap = i_btn_lap;
    assign o_lap_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_cu.sv
// Self-checking bench for stopwatch_cu: vector table, hand sequences and a
// randomized run against an event-level reference model.
module tb_stopwatch_cu;
    localparam int CC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b0, btn_run = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
    logic       o_run, o_clear, o_lap_hold;
    logic [1:0] o_state;

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_cu #(.CLEAR_CYCLES(CC)) dut (
        .clk(clk), .reset(reset), .cs(cs),
        .i_btn_run(btn_run), .i_btn_clear(btn_clear), .i_btn_lap(btn_lap),
        .o_run(o_run), .o_clear(o_clear), .o_lap_hold(o_lap_hold), .o_state(o_state)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=stopped, 1=running, 2=clearing; clear_left counts remaining pulse cycles.
    int m_mode, m_left;
    bit m_hold, m_pr, m_pc, m_pl;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_hold = 0; m_pr = 0; m_pc = 0; m_pl = 0;
    endtask

    task automatic model_edge(input bit c, input bit r, input bit cl, input bit l);
        bit re, ce, le;
        re = c && r && !m_pr;
        ce = c && cl && !m_pc;
        le = c && l && !m_pl;
        m_pr = r; m_pc = cl; m_pl = l;
`ifdef STOPWATCH_LAP_EN
        if (le && m_mode == 1) m_hold = !m_hold;
        else if (le && m_mode == 0) m_hold = 0;
`endif
        if (m_mode == 2) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 0;
        end else if (m_mode == 0) begin
            if (ce) begin m_mode = 2; m_left = CC; end
            else if (re) m_mode = 1;
        end else if (re) begin
            m_mode = 0;
        end
        if (m_mode == 2) m_hold = 0;
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input bit er, input bit ec, input bit eh, input logic [1:0] es);
        check({tag, ".run"},   {1'b0, o_run},      {1'b0, er});
        check({tag, ".clear"}, {1'b0, o_clear},    {1'b0, ec});
        check({tag, ".hold"},  {1'b0, o_lap_hold}, {1'b0, eh});
        check({tag, ".state"}, o_state, es);
    endtask

    task automatic check_model(input string tag);
        check_all(tag, m_mode == 1, m_mode == 2, m_hold, 2'(m_mode));
    endtask

    // Drive at the falling edge, let the rising edge act, sample 1 time unit later.
    task automatic step(input bit c, input bit r, input bit cl, input bit l);
        @(negedge clk);
        cs = c; btn_run = r; btn_clear = cl; btn_lap = l;
        @(posedge clk);
        model_edge(c, r, cl, l);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cs = 0; btn_run = 0; btn_clear = 0; btn_lap = 0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit         c, r, cl, l;
        bit         er, ec;
        logic [1:0] es;
    } vec_t;

    vec_t vecs[23];

    initial begin
        vecs = '{
            '{1,1,0,0, 1,0,2'b01}, '{1,1,0,0, 1,0,2'b01}, '{1,1,0,0, 1,0,2'b01},
            '{1,1,0,0, 1,0,2'b01}, '{1,1,0,0, 1,0,2'b01}, '{1,0,0,0, 1,0,2'b01},
            '{1,1,0,0, 0,0,2'b00}, '{1,0,0,0, 0,0,2'b00}, '{1,0,1,0, 0,1,2'b10},
            '{1,1,0,0, 0,1,2'b10}, '{1,0,0,0, 0,1,2'b10}, '{1,0,0,0, 0,0,2'b00},
            '{1,1,0,0, 1,0,2'b01}, '{1,0,1,0, 1,0,2'b01}, '{1,0,0,0, 1,0,2'b01},
            '{0,1,1,1, 1,0,2'b01}, '{0,0,0,0, 1,0,2'b01}, '{0,1,0,0, 1,0,2'b01},
            '{1,1,0,0, 1,0,2'b01}, '{1,0,0,0, 1,0,2'b01}, '{1,1,0,0, 0,0,2'b00},
            '{1,0,0,0, 0,0,2'b00}, '{1,1,1,0, 0,1,2'b10}
        };

        // Reset state, sampled while reset is held.
        #2;
        check_all("reset", 0, 0, 0, 2'b00);
        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].c, vecs[i].r, vecs[i].cl, vecs[i].l);
            check_all($sformatf("vec%0d", i), vecs[i].er, vecs[i].ec, 1'b0, vecs[i].es);
        end

        // Asynchronous reset in the middle of a clear pulse.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 0, 0, 0, 2'b00);
        @(negedge clk);
        reset = 1'b0; cs = 0; btn_run = 0; btn_clear = 0; btn_lap = 0;
        model_reset();
        step(1, 0, 0, 0);
        check_all("post_reset", 0, 0, 0, 2'b00);

        // Run events two edges apart: start then stop.
        step(1, 1, 0, 0); check_all("spaced1", 1, 0, 0, 2'b01);
        step(1, 0, 0, 0); check_all("spaced2", 1, 0, 0, 2'b01);
        step(1, 1, 0, 0); check_all("spaced3", 0, 0, 0, 2'b00);
        step(1, 0, 0, 0);

        // Lap behaviour.
        step(1, 1, 0, 0); step(1, 0, 0, 0);
        step(1, 0, 0, 1);
`ifdef STOPWATCH_LAP_EN
        check_all("lap_run", 1, 0, 1, 2'b01);
        step(1, 1, 0, 0); check_all("lap_stop", 0, 0, 1, 2'b00);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1); check_all("lap_release", 0, 0, 0, 2'b00);
`else
        check_all("lap_run", 1, 0, 0, 2'b01);
        step(1, 1, 0, 0); check_all("lap_stop", 0, 0, 0, 2'b00);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1); check_all("lap_release", 0, 0, 0, 2'b00);
`endif

        // Randomized run against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bit c, r, cl, l;
            c  = ($urandom_range(0, 9) != 0);
            r  = ($urandom_range(0, 2) == 0);
            cl = ($urandom_range(0, 6) == 0);
            l  = ($urandom_range(0, 3) == 0);
            step(c, r, cl, l);
            check_model($sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
